audio_dsm_out: RTL and testbench
================================

AUDIO_DSM_OUT -- requirements
Module: audio_dsm_out

Interface
REQ-001 Parameter CHANNELS, default 2, number of audio channels (1..8).
REQ-002 Parameter SAMPLE_W, default 16, signed two's-complement sample width per channel (8..24).
REQ-003 Parameter FIFO_DEPTH, default 8, frame FIFO depth in frames; power of two, >=2.
REQ-004 Parameter OSR, default 256, sys_clock cycles per output sample period (>=2).
REQ-005 sys_clock  in  1  sole clock; all state on its rising edge.
REQ-006 reset_  in  1  asynchronous, active-low reset.
REQ-007 enable  in  1  1 = sample tick counter runs and FIFO pops; 0 = counter frozen, modulators keep running on held sample.
REQ-008 wr_valid  in  1  frame write request.
REQ-009 wr_data  in  CHANNELS*SAMPLE_W  frame; channel k at bits [k*SAMPLE_W +: SAMPLE_W].
REQ-010 wr_ready  out  1  = !audio_fifo_full.
REQ-011 audio_fifo_full  out  1  FIFO holds FIFO_DEPTH frames.
REQ-012 audio_fifo_empty  out  1  FIFO holds 0 frames.
REQ-013 fifo_level  out  $clog2(FIFO_DEPTH)+1  frames currently stored.
REQ-014 underrun  out  1  one-cycle pulse when a sample tick finds FIFO empty.
REQ-015 audio_out  out  CHANNELS  1-bit delta-sigma output per channel, registered.

Function
REQ-016 A write occurs in a cycle where wr_valid && wr_ready; wr_data is captured that cycle.
REQ-017 Tick counter counts 0..OSR-1 while enable=1 and wraps; sample_tick asserts in the cycle the counter equals OSR-1.
REQ-018 On sample_tick with FIFO not empty: pop head frame into held-sample registers; new value drives modulator from the next cycle.
REQ-019 On sample_tick with FIFO empty: held samples unchanged (last value repeated), underrun pulses next cycle, no pop.
REQ-020 Simultaneous write and pop: both occur; fifo_level unchanged; full state cannot block the pop.
REQ-021 Write and tick in the same cycle on an empty FIFO: tick sees empty (underrun), write stored, level becomes 1.
REQ-022 Write when full: ignored (wr_ready=0), no state change, even if a pop occurs the same cycle.
REQ-023 Read/write pointers are $clog2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH; level derived from a separate counter.
REQ-024 Per channel: offset = sample XOR MSB mask (signed -> offset binary); accumulator SAMPLE_W+1 bits; each cycle acc <= {1'b0,acc[SAMPLE_W-1:0]} + offset; audio_out[k] <= acc carry bit.
REQ-025 Output density over time = offset/2^SAMPLE_W: sample 0 -> 50% ones, max positive -> all-but-one-in-2^SAMPLE_W ones, most negative -> all zeros.
REQ-026 Modulator runs every cycle regardless of enable; latency from held-sample update to first affected audio_out bit = 2 cycles.
REQ-027 All channels update held samples in the same cycle; no inter-channel skew.

Reset
REQ-028 While reset_=0: FIFO pointers/level=0, tick counter=0, held samples=0 (midscale), accumulators=0, audio_out=0, underrun=0.
REQ-029 Outputs after reset: audio_fifo_empty=1, audio_fifo_full=0, wr_ready=1, fifo_level=0.
REQ-030 Reset asserted mid-operation discards all FIFO contents and held samples immediately (asynchronously); no partial frame survives.
REQ-031 FIFO storage array needs no reset; only pointers and valid-state control are reset.

Structure
REQ-032 Shared package audio_pkg holds default constants (SAMPLE_W, OSR, FIFO_DEPTH) and a level-width function ($clog2(depth)+1).
REQ-033 One sub-module, audio_dsm_channel (SAMPLE_W param; held sample in, audio_out bit out), instantiated CHANNELS times via generate.
REQ-034 FIFO and tick counter live in the top module; no clock dividers, no derived clocks.

Verification (CHANNELS=2, SAMPLE_W=16, FIFO_DEPTH=8, OSR=256)
REQ-035 Reset: pulse reset_ low 1 cycle, enable=1, no writes -> audio_out alternates 0/1 per channel after 2 cycles, underrun pulses every 256 cycles.
REQ-036 Fill: write 9 frames back-to-back with enable=0 -> 8 accepted, fifo_level=8, audio_fifo_full=1, wr_ready=0 on 9th.
REQ-037 Density: write {L=16'h4000, R=16'hC000}, enable=1 -> over 256 cycles after pop, L ones=192, R ones=64 (+/-1).
REQ-038 Concurrency: FIFO full, wr_valid=1 on tick cycle -> pop occurs, write refused, level 7; next cycle write accepted, level 8.
REQ-039 Empty-edge: FIFO empty, write on tick cycle -> underrun pulse, level=1, frame popped on the following tick.
REQ-040 Mid-reset: reset_ low while level=5 -> level=0, empty=1, audio_out=0 immediately; held samples read as midscale.

Source files
------------

// File: rtl/audio_pkg.sv
// Shared constants and helpers for the delta-sigma audio output block.
//   DEF_*    : default parameter values used by audio_dsm_out and its channels
//   level_w  : width of a 0..depth occupancy count
package audio_pkg;

    localparam int DEF_CHANNELS   = 2;
    localparam int DEF_SAMPLE_W   = 16;
    localparam int DEF_FIFO_DEPTH = 8;
    localparam int DEF_OSR        = 256;

    // The count must represent "depth" itself, hence the extra bit.
    function automatic int level_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/audio_dsm_out_if.sv
// Frame write channel of the audio delta-sigma output block.
//   wr_valid : producer has a frame
//   wr_data  : frame, channel k at [k*SAMPLE_W +: SAMPLE_W]
//   wr_ready : block can accept a frame this cycle
interface audio_dsm_out_if #(
    parameter int CHANNELS = 2,
    parameter int SAMPLE_W = 16
);
    logic                         wr_valid;
    logic [CHANNELS*SAMPLE_W-1:0] wr_data;
    logic                         wr_ready;

    modport master (output wr_valid, output wr_data, input  wr_ready);
    modport slave  (input  wr_valid, input  wr_data, output wr_ready);
endinterface

// File: rtl/audio_dsm_channel.sv
// First-order delta-sigma modulator for one audio channel.
//   sys_clock   : clock
//   reset_      : async active-low reset
//   held_sample : signed sample currently being played
//   audio_out   : registered 1-bit density output
module audio_dsm_channel
    import audio_pkg::*;
#(
    parameter int SAMPLE_W = DEF_SAMPLE_W
) (
    input  logic                sys_clock,
    input  logic                reset_,
    input  logic [SAMPLE_W-1:0] held_sample,
    output logic                audio_out
);

    localparam logic [SAMPLE_W-1:0] MSB_MASK = {1'b1, {(SAMPLE_W-1){1'b0}}};

    // Flipping the sign bit maps two's complement onto offset binary, so
    // midscale (0) becomes 2^(SAMPLE_W-1) and yields a 50% ones density.
    logic [SAMPLE_W-1:0] offset;
    logic [SAMPLE_W:0]   acc;

    assign offset = held_sample ^ MSB_MASK;

    // The carry out of the accumulator is the output bit; it is dropped
    // before the next add, which gives the overflow-density behaviour.
    always_ff @(posedge sys_clock or negedge reset_) begin
        if (!reset_) begin
            acc       <= '0;
            audio_out <= 1'b0;
        end else begin
            acc       <= {1'b0, acc[SAMPLE_W-1:0]} + {1'b0, offset};
            audio_out <= acc[SAMPLE_W];
        end
    end

endmodule

// File: rtl/audio_dsm_out.sv
// Multi-channel delta-sigma audio output: frame FIFO, sample-rate tick
// counter, held-sample registers and one modulator per channel.
//   sys_clock        : sole clock
//   reset_           : async active-low reset
//   enable           : run tick counter / allow pops
//   wr               : frame write channel (slave)
//   audio_fifo_full  : FIFO holds FIFO_DEPTH frames
//   audio_fifo_empty : FIFO holds no frames
//   fifo_level       : frames stored
//   underrun         : one-cycle pulse after a tick found the FIFO empty
//   audio_out        : 1-bit modulator output per channel
module audio_dsm_out
    import audio_pkg::*;
#(
    parameter int CHANNELS   = DEF_CHANNELS,
    parameter int SAMPLE_W   = DEF_SAMPLE_W,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int OSR        = DEF_OSR
) (
    input  logic                             sys_clock,
    input  logic                             reset_,
    input  logic                             enable,
    audio_dsm_out_if.slave                   wr,
    output logic                             audio_fifo_full,
    output logic                             audio_fifo_empty,
    output logic [level_w(FIFO_DEPTH)-1:0]   fifo_level,
    output logic                             underrun,
    output logic [CHANNELS-1:0]              audio_out
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = level_w(FIFO_DEPTH);
    localparam int CNT_W = $clog2(OSR);
    localparam int FRM_W = CHANNELS * SAMPLE_W;

    logic [CNT_W-1:0]                   tick_cnt;
    logic                               sample_tick;
    logic [PTR_W-1:0]                   wr_ptr;
    logic [PTR_W-1:0]                   rd_ptr;
    logic                               do_wr;
    logic                               do_rd;
    logic [FIFO_DEPTH-1:0][FRM_W-1:0]   fifo_mem;
    logic [CHANNELS-1:0][SAMPLE_W-1:0]  held;

    // Tick is gated by enable so a counter frozen at OSR-1 does not
    // keep firing.
    assign sample_tick      = enable && (tick_cnt == CNT_W'(OSR - 1));
    assign audio_fifo_full  = (fifo_level == LVL_W'(FIFO_DEPTH));
    assign audio_fifo_empty = (fifo_level == '0);
    assign wr.wr_ready      = !audio_fifo_full;

    // Write acceptance only looks at the pre-cycle full flag, so a pop in
    // the same cycle never opens room for a write to a full FIFO.
    assign do_wr = wr.wr_valid && !audio_fifo_full;
    assign do_rd = sample_tick && !audio_fifo_empty;

    always_ff @(posedge sys_clock or negedge reset_) begin
        if (!reset_) begin
            tick_cnt <= '0;
        end else if (enable) begin
            tick_cnt <= sample_tick ? '0 : tick_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge sys_clock or negedge reset_) begin
        if (!reset_) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            underrun   <= 1'b0;
        end else begin
            underrun <= sample_tick && audio_fifo_empty;
            if (do_wr) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_rd) rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_wr, do_rd})
                2'b10:   fifo_level <= fifo_level + LVL_W'(1);
                2'b01:   fifo_level <= fifo_level - LVL_W'(1);
                default: fifo_level <= fifo_level;
            endcase
        end
    end

    // Storage is only meaningful behind the pointers, so it carries no reset.
    always_ff @(posedge sys_clock) begin
        if (do_wr) fifo_mem[wr_ptr] <= wr.wr_data;
    end

    // All channels load together from one frame, so there is no skew.
    always_ff @(posedge sys_clock or negedge reset_) begin
        if (!reset_) begin
            held <= '0;
        end else if (do_rd) begin
            held <= fifo_mem[rd_ptr];
        end
    end

    for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
        audio_dsm_channel #(
            .SAMPLE_W (SAMPLE_W)
        ) u_ch (
            .sys_clock   (sys_clock),
            .reset_      (reset_),
            .held_sample (held[k]),
            .audio_out   (audio_out[k])
        );
    end

endmodule

// File: tb/tb_audio_dsm_out.sv
// Self-checking bench for audio_dsm_out: a cycle-level reference model
// (FIFO as a queue, modulator as modular arithmetic) pushes the expected
// outputs of every cycle into a queue; a monitor on the falling edge pops
// and compares. Directed sequences add occupancy/density checks.
module tb_audio_dsm_out;

    localparam int CH    = 2;
    localparam int W     = 16;
    localparam int DEPTH = 8;
    localparam int OSR   = 256;
    localparam int LW    = 4;

    logic          sys_clock = 1'b0;
    logic          reset_;
    logic          enable;
    logic          full, empty, underrun;
    logic [LW-1:0] level;
    logic [CH-1:0] aout;

    audio_dsm_out_if #(.CHANNELS(CH), .SAMPLE_W(W)) wr_if ();

    audio_dsm_out #(
        .CHANNELS(CH), .SAMPLE_W(W), .FIFO_DEPTH(DEPTH), .OSR(OSR)
    ) dut (
        .sys_clock        (sys_clock),
        .reset_           (reset_),
        .enable           (enable),
        .wr               (wr_if),
        .audio_fifo_full  (full),
        .audio_fifo_empty (empty),
        .fifo_level       (level),
        .underrun         (underrun),
        .audio_out        (aout)
    );

    always #5 sys_clock = ~sys_clock;

    typedef struct packed {
        logic [CH-1:0] aout;
        logic          und;
        logic [LW-1:0] lvl;
        logic          full;
        logic          empty;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string nm, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s at %0t: actual=%0h required=%0h", nm, $time, act, req);
        end
    endtask

    // ---------------- reference model ----------------
    logic [CH*W-1:0] m_fifo[$];
    logic [CH*W-1:0] m_f;
    int              m_cnt;
    longint          m_acc[CH];
    int              m_held[CH];
    logic [CH-1:0]   m_out;
    logic            m_und;
    bit              m_tick, m_wr;
    exp_t            m_e;

    always @(posedge sys_clock) begin
        if (!reset_) begin
            m_fifo.delete();
            m_cnt = 0;
            m_out = '0;
            m_und = 1'b0;
            for (int k = 0; k < CH; k++) begin
                m_acc[k]  = 0;
                m_held[k] = 0;
            end
        end else begin
            m_tick = enable && (m_cnt == OSR - 1);
            m_wr   = wr_if.wr_valid && (m_fifo.size() < DEPTH);
            for (int k = 0; k < CH; k++) begin
                m_out[k] = (m_acc[k] >= 2**W);
                m_acc[k] = (m_acc[k] % (2**W)) + longint'(m_held[k] + 2**(W-1));
            end
            m_und = m_tick && (m_fifo.size() == 0);
            if (m_tick && m_fifo.size() > 0) begin
                m_f = m_fifo.pop_front();
                for (int k = 0; k < CH; k++) m_held[k] = int'($signed(m_f[k*W +: W]));
            end
            if (m_wr) m_fifo.push_back(wr_if.wr_data);
            if (enable) m_cnt = (m_cnt == OSR - 1) ? 0 : m_cnt + 1;
            m_e.aout  = m_out;
            m_e.und   = m_und;
            m_e.lvl   = LW'(m_fifo.size());
            m_e.full  = (m_fifo.size() == DEPTH);
            m_e.empty = (m_fifo.size() == 0);
            exp_q.push_back(m_e);
        end
    end

    // ---------------- monitor ----------------
    exp_t mon_e, mon_a;

    always @(negedge sys_clock) begin
        if (!reset_) begin
            exp_q.delete();
            chk("rst_state", {aout, underrun, level, full, empty, wr_if.wr_ready},
                {2'b00, 1'b0, 4'd0, 1'b0, 1'b1, 1'b1});
        end else if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            mon_a = '{aout: aout, und: underrun, lvl: level, full: full, empty: empty};
            chk("cycle_outputs", int'(mon_a), int'(mon_e));
            chk("wr_ready", int'(wr_if.wr_ready), int'(!mon_e.full));
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input int n);
        repeat (n) @(posedge sys_clock);
        #1;
    endtask

    task automatic rst_pulse();
        reset_ = 1'b0;
        cyc(1);
        reset_ = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int u, cl, cr, b;
        reset_         = 1'b0;
        enable         = 1'b0;
        wr_if.wr_valid = 1'b0;
        wr_if.wr_data  = '0;
        cyc(2);

        // Idle after reset: midscale toggling, underrun once per OSR cycles.
        reset_ = 1'b1;
        enable = 1'b1;
        u = 0;
        for (int i = 0; i < 600; i++) begin
            cyc(1);
            if (underrun) u++;
        end
        chk("idle_underruns", u, 2);

        // Fill past capacity with the tick counter frozen.
        rst_pulse();
        enable = 1'b0;
        for (int i = 0; i < 9; i++) begin
            wr_if.wr_valid = 1'b1;
            wr_if.wr_data  = {$urandom, $urandom};
            if (i == 8) chk("wr_ready_9th", int'(wr_if.wr_ready), 0);
            cyc(1);
        end
        wr_if.wr_valid = 1'b0;
        chk("fill_level", int'(level), 8);
        chk("fill_full", int'(full), 1);

        // Full FIFO, write held on the tick cycle: pop wins, write refused.
        enable = 1'b1;
        wr_if.wr_valid = 1'b1;
        for (b = 0; b < 600 && m_cnt != OSR - 1; b++) begin
            wr_if.wr_data = {$urandom, $urandom};
            cyc(1);
        end
        chk("tick_found_full", int'(b < 600), 1);
        cyc(1);
        chk("conc_level_pop", int'(level), 7);
        cyc(1);
        chk("conc_level_wr", int'(level), 8);
        wr_if.wr_valid = 1'b0;

        // Drain, then write exactly on a tick while empty.
        for (b = 0; b < 3000 && level != 0; b++) cyc(1);
        chk("drained", int'(level), 0);
        for (b = 0; b < 600 && m_cnt != OSR - 1; b++) cyc(1);
        wr_if.wr_valid = 1'b1;
        wr_if.wr_data  = {$urandom, $urandom};
        cyc(1);
        wr_if.wr_valid = 1'b0;
        chk("edge_underrun", int'(underrun), 1);
        chk("edge_level", int'(level), 1);
        cyc(OSR);
        chk("edge_popped", int'(level), 0);

        // Density: L = +0.5 FS, R = -0.5 FS.
        rst_pulse();
        enable = 1'b0;
        wr_if.wr_valid = 1'b1;
        wr_if.wr_data  = {16'hC000, 16'h4000};
        cyc(1);
        wr_if.wr_valid = 1'b0;
        enable = 1'b1;
        for (b = 0; b < 600 && level != 0; b++) cyc(1);
        cyc(2);
        cl = 0;
        cr = 0;
        for (int i = 0; i < 256; i++) begin
            cyc(1);
            cl += int'(aout[0]);
            cr += int'(aout[1]);
        end
        chk("density_L_in_range", (cl >= 191 && cl <= 193) ? 192 : cl, 192);
        chk("density_R_in_range", (cr >= 63 && cr <= 65) ? 64 : cr, 64);

        // Randomised traffic with enable toggling.
        rst_pulse();
        for (int i = 0; i < 3000; i++) begin
            wr_if.wr_valid = ($urandom_range(0, 199) == 0);
            wr_if.wr_data  = {$urandom, $urandom};
            enable         = ($urandom_range(0, 9) != 0);
            cyc(1);
        end
        wr_if.wr_valid = 1'b0;

        // Reset mid-operation, asserted between clock edges.
        rst_pulse();
        enable = 1'b0;
        for (int i = 0; i < 5; i++) begin
            wr_if.wr_valid = 1'b1;
            wr_if.wr_data  = {$urandom, $urandom};
            cyc(1);
        end
        wr_if.wr_valid = 1'b0;
        chk("pre_rst_level", int'(level), 5);
        #2;
        reset_ = 1'b0;
        #1;
        chk("async_rst_level", int'(level), 0);
        chk("async_rst_empty", int'(empty), 1);
        chk("async_rst_aout", int'(aout), 0);
        cyc(2);
        reset_ = 1'b1;
        enable = 1'b1;
        cyc(40);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
